// File: rtl/feedback_pkg.sv
// Shared definitions for the feedback receiver: byte type codes, status bit
// positions, link/filter state encodings and the byte classifier.
package feedback_pkg;

  localparam logic [1:0] TYPE_STATUS = 2'b01;
  localparam logic [1:0] TYPE_ECHO   = 2'b10;

  localparam int BIT_PLAYER_READY = 2;
  localparam int BIT_HAS_ITEM     = 3;
  localparam int BIT_TARGET_READY = 4;
  localparam int BIT_GAME_RUNNING = 5;

  typedef enum logic {
    LINK_DOWN = 1'b0,
    LINK_UP   = 1'b1
  } link_state_e;

  typedef enum logic {
    NO_CAND   = 1'b0,
    HAVE_CAND = 1'b1
  } filter_state_e;

  typedef enum logic [1:0] {
    BYTE_STATUS = 2'd0,
    BYTE_ECHO   = 2'd1,
    BYTE_ERROR  = 2'd2
  } byte_kind_e;

  // A status byte with either of its top two bits set is malformed.
  function automatic byte_kind_e classify(input logic [7:0] b);
    if (b[1:0] == TYPE_ECHO) return BYTE_ECHO;
    if (b[1:0] == TYPE_STATUS && b[7:6] == 2'b00) return BYTE_STATUS;
    return BYTE_ERROR;
  endfunction

endpackage

// File: rtl/feedback_receiver_link_watchdog.sv
// Link liveness tracker: counts idle cycles in LINK_UP and drops the link
// after TIMEOUT_CYCLES without a kick. A kick in the expiring cycle wins.
module link_watchdog
  import feedback_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 153600
) (
  input  logic clock,
  input  logic reset,
  input  logic kick,
  input  logic freeze,
  output logic alive,
  output logic expire
);

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  link_state_e     state_q, state_d;
  logic [WD_W-1:0] cnt_q, cnt_d;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= LINK_DOWN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (freeze) begin
      cnt_d = '0;
    end else if (kick) begin
      state_d = LINK_UP;
      cnt_d   = '0;
    end else if (state_q == LINK_UP) begin
      if (cnt_q == WD_LAST) begin
        state_d = LINK_DOWN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + WD_W'(1);
      end
    end
  end

  always_comb begin
    alive  = (state_q == LINK_UP);
    expire = (state_q == LINK_UP) && !freeze && !kick && (cnt_q == WD_LAST);
  end

endmodule

// File: rtl/feedback_receiver.sv
// Decodes the status/echo byte stream from the UART receiver into registered
// flags, pulses and saturating counters, with glitch filtering and link watchdog.
module feedback_receiver
  import feedback_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 153600,
  parameter bit          FILTER_EN      = 1'b1,
  parameter int          CNT_W          = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             script_mode,
  input  logic [7:0]       data_bits,
  input  logic             data_valid,
  output logic             player_ready,
  output logic             has_item,
  output logic             target_ready,
  output logic             game_running,
  output logic             ready_rise,
  output logic [5:0]       target_echo,
  output logic             echo_valid,
  output logic             link_alive,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [7:0]       last_byte
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic          valid_q;
  logic          blocked_q;
  byte_kind_e    kind;
  logic          take;
  logic          is_status;
  logic          is_echo;
  logic          is_error;
  logic          accept;
  logic          apply;
  logic          expire;
  filter_state_e fstate_q, fstate_d;
  logic [7:0]    cand_q, cand_d;

  always_comb begin
    kind      = classify(data_bits);
    take      = data_valid && !valid_q && !blocked_q && !script_mode;
    is_status = take && (kind == BYTE_STATUS);
    is_echo   = take && (kind == BYTE_ECHO);
    is_error  = take && (kind == BYTE_ERROR);
    accept    = is_status || is_echo;
  end

  // Status glitch filter: a status byte is applied only when it repeats the
  // previous status byte seen since the candidate was last cleared.
  always_ff @(posedge clock) begin
    if (!reset) begin
      fstate_q <= NO_CAND;
      cand_q   <= '0;
    end else begin
      fstate_q <= fstate_d;
      cand_q   <= cand_d;
    end
  end

  always_comb begin
    fstate_d = fstate_q;
    cand_d   = cand_q;
    if (script_mode || expire) begin
      fstate_d = NO_CAND;
      cand_d   = '0;
    end else if (is_status) begin
      fstate_d = HAVE_CAND;
      cand_d   = data_bits;
    end
  end

  always_comb begin
    apply = is_status &&
            (!FILTER_EN || (fstate_q == HAVE_CAND && data_bits == cand_q));
  end

  // blocked_q keeps a byte that straddles reset from being sampled after it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q      <= 1'b0;
      blocked_q    <= data_valid;
      player_ready <= 1'b0;
      has_item     <= 1'b0;
      target_ready <= 1'b0;
      game_running <= 1'b0;
      ready_rise   <= 1'b0;
      target_echo  <= '0;
      echo_valid   <= 1'b0;
      frame_cnt    <= '0;
      err_cnt      <= '0;
      last_byte    <= '0;
    end else begin
      valid_q    <= data_valid;
      ready_rise <= 1'b0;
      echo_valid <= 1'b0;
      if (!data_valid) blocked_q <= 1'b0;

      if (apply) begin
        player_ready <= data_bits[BIT_PLAYER_READY];
        has_item     <= data_bits[BIT_HAS_ITEM];
        target_ready <= data_bits[BIT_TARGET_READY];
        game_running <= data_bits[BIT_GAME_RUNNING];
        ready_rise   <= data_bits[BIT_TARGET_READY] && !target_ready;
      end

      if (is_echo) begin
        target_echo <= data_bits[7:2];
        echo_valid  <= 1'b1;
      end

      if (accept && frame_cnt != CNT_MAX) frame_cnt <= frame_cnt + CNT_W'(1);
      if (is_error && err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_W'(1);
      if (accept || is_error) last_byte <= data_bits;
    end
  end

  link_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock (clock),
    .reset (reset),
    .kick  (accept),
    .freeze(script_mode),
    .alive (link_alive),
    .expire(expire)
  );

endmodule

// File: doc/feedback_receiver.md
Name: feedback_receiver

Overview:
- Consumes the GenshinKitchen → board byte stream from the UART receive side (io_dataOut_bits / io_dataOut_valid).
- Decodes status and target-echo bytes, filters glitches and tracks link liveness.
- Provides registered flags, pulses and counters for the operate/target machines and the board LEDs.
- Sits in the top level beside the script memory and is clocked by the 16x baud UART clock.

Parameters:
- TIMEOUT_CYCLES, 153600, idle cycles without an accepted byte before the link is declared down (1 s at 153.6 kHz).
- FILTER_EN, 1, when 1 a status byte is applied only after two identical consecutive status bytes; when 0 each status byte is applied immediately.
- CNT_W, 8, width of frame_cnt and err_cnt.

Ports:
- clock  in  1  UART clock (same as the UART module).
- reset  in  1  synchronous, active-low reset.
- script_mode  in  1  1 while the script memory owns the byte stream; bytes are ignored.
- data_bits  in  8  received byte; valid only while data_valid=1.
- data_valid  in  1  level; may stay high for several cycles per byte.
- player_ready  out  1  status bit 2.
- has_item  out  1  status bit 3.
- target_ready  out  1  status bit 4.
- game_running  out  1  status bit 5.
- ready_rise  out  1  one-cycle pulse when target_ready goes 0→1.
- target_echo  out  6  last echoed target machine index.
- echo_valid  out  1  one-cycle pulse when target_echo is updated.
- link_alive  out  1  1 in LINK_UP.
- frame_cnt  out  CNT_W  accepted bytes, saturating.
- err_cnt  out  CNT_W  malformed bytes, saturating.
- last_byte  out  8  last sampled byte, for the LEDs.

Behaviour:
- Reset (reset=0 at a clock edge): all outputs 0, valid_q=0, candidate cleared, watchdog 0, state LINK_DOWN.
- Sampling: a byte is sampled in cycle N if data_valid=1 and valid_q=0; valid_q<=data_valid every cycle. Holding data_valid high samples exactly once.
- Outputs from the byte in cycle N are visible in cycle N+1. Pulses are high only in N+1.
- Script mode: if script_mode=1 in cycle N, the sampled byte is dropped and nothing changes except valid_q.
  - The watchdog is held at 0 and the link state is frozen.
  - The candidate is cleared.
- Byte types are decoded from bits[1:0]:
  - 01, status byte: bits[7:6] must be 00, otherwise it is an error.
  - 10, echo byte: target_echo<=bits[7:2] and echo_valid pulses. An index of 0 is legal.
  - 00 or 11: error.
- Errors increment err_cnt and update last_byte. Flags, frame_cnt and the watchdog are unchanged.
- Accepted bytes (valid status or echo) increment frame_cnt, update last_byte, clear the watchdog and set state LINK_UP.
  - With FILTER_EN=1, a status byte that is not yet applied still counts as accepted.
- Status filter (FILTER_EN=1) uses substates NO_CAND and HAVE_CAND.
  - NO_CAND + status byte S → HAVE_CAND, cand<=S.
  - HAVE_CAND + S==cand → apply S to the flags, stay in HAVE_CAND.
  - HAVE_CAND + S!=cand → cand<=S, flags unchanged.
  - Echo and error bytes do not touch the candidate.
- ready_rise pulses when an applied status changes target_ready from 0 to 1.
- Watchdog: in LINK_UP, when no byte is accepted it increments every cycle.
  - At TIMEOUT_CYCLES-1 → LINK_DOWN: link_alive<=0, watchdog<=0, candidate cleared.
  - Status flags keep their last values.
- Simultaneous accept and timeout in the same cycle: the accept wins and the link stays up.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Reset asserted mid-byte: the next sample requires a fresh 0→1 on data_valid after reset is released.

Decomposition:
- feedback_pkg holds:
  - type codes TYPE_STATUS=2'b01 and TYPE_ECHO=2'b10;
  - bit indices for player_ready/has_item/target_ready/game_running;
  - link-state and filter-state enums.
- One sub-module, link_watchdog, holds the timeout counter and the LINK_UP/LINK_DOWN state.
  - Inputs: kick, freeze.
  - Outputs: alive, expire pulse.

Test Plan:
- Reset then data_valid held high 5 cycles with 8'h15 (FILTER_EN=1) → frame_cnt=1, flags unchanged, link_alive=1 next cycle.
- Send 8'h15 twice → second byte gives player_ready=1, target_ready=1, ready_rise pulses once, has_item=0, game_running=0.
- Send 8'h16 (echo, index 5) → target_echo=5, echo_valid high for exactly 1 cycle.
- Send 8'h00, 8'h43 (bits[7:6]≠00) → err_cnt=2, flags unchanged, last_byte=8'h43.
- script_mode=1 while 8'h15 is sent → no counter or flag change; link state frozen, resumes after script_mode falls.
- Run TIMEOUT_CYCLES=16 with no bytes after one accept → link_alive falls at cycle 16, flags retained. Run 300 accepted bytes → frame_cnt=255.
